game_sequencer: RTL and testbench



---
 rtl/game_pkg.sv | 15 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/game_sequencer.sv | 134 +++++++++++++
 tb/tb_game_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and widths for the dodge-game run-control logic.
package game_pkg;
    localparam int STATE_W = 3;
    localparam int SCORE_W = 32;
    localparam int TICK_W  = 24;
    localparam int LEVEL_W = 3;

    typedef enum logic [STATE_W-1:0] {
        RESET_HOLD = 3'd0,
        WAIT_START = 3'd1,
        RUN        = 3'd2,
        PAUSED     = 3'd3,
        OVER       = 3'd4
    } state_e;
endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-count debouncer, one-cycle
// pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE = 500000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic press_o
);
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Any sample matching the accepted level restarts the run of differing samples.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                stable_q <= sync2_q;
                press_q  <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_o = press_q;
endmodule

// File: rtl/game_sequencer.sv
// Run-control FSM for the dodge game: start/pause/restart, game-over hold,
// high-score latch and score-driven speed level scheduling.
module game_sequencer
    import game_pkg::*;
#(
    parameter int                 RST_CYCLES  = 3,
    parameter int                 DEBOUNCE    = 500000,
    parameter int                 OVER_HOLD   = 25000000,
    parameter int                 LEVEL_STEP  = 10,
    parameter int                 MAX_LEVEL   = 7,
    parameter logic [TICK_W-1:0]  BASE_PERIOD = 24'd12500000,
    parameter logic [TICK_W-1:0]  PERIOD_STEP = 24'd1250000,
    parameter logic [TICK_W-1:0]  MIN_PERIOD  = 24'd2500000
) (
    input  logic               system_clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               collision,
    input  logic [SCORE_W-1:0] score,
    output logic               sub_rst,
    output logic               run,
    output logic               paused,
    output logic               game_over,
    output logic [LEVEL_W-1:0] level,
    output logic [TICK_W-1:0]  tick_period,
    output logic [SCORE_W-1:0] high_score,
    output logic [STATE_W-1:0] state_o
);
    localparam int HOLD_MAX = (OVER_HOLD > RST_CYCLES) ? OVER_HOLD : RST_CYCLES;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);

    logic               press;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sub_rst_q, run_q, paused_q, over_q;
    logic [LEVEL_W-1:0] level_q;
    logic [SCORE_W-1:0] next_thr_q;
    logic [SCORE_W-1:0] high_score_q;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [TICK_W:0]    step_amt, period_diff;
    logic               rst_done, over_done;

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_start_db (
        .clk_i   (system_clk),
        .rst_n_i (rst_n),
        .btn_i   (start),
        .press_o (press)
    );

    assign rst_done  = (cnt_q == CNT_W'(RST_CYCLES - 1));
    assign over_done = (cnt_q == CNT_W'(OVER_HOLD));

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET_HOLD: if (rst_done) state_d = WAIT_START;
            WAIT_START: if (press) state_d = RUN;
            RUN: begin
                if (collision)  state_d = OVER;
                else if (press) state_d = PAUSED;
            end
            PAUSED:     if (press) state_d = RUN;
            OVER:       if (press && over_done) state_d = RESET_HOLD;
            default:    state_d = RESET_HOLD;
        endcase

        // Counter restarts on every state change and saturates at the OVER hold.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == RESET_HOLD || (state_q == OVER && !over_done)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Extra top bit turns an oversized reduction into a visible borrow instead of a wrap.
    always_comb begin
        step_amt    = (TICK_W+1)'(level_q) * {1'b0, PERIOD_STEP};
        period_diff = {1'b0, BASE_PERIOD} - step_amt;
        tick_d      = period_diff[TICK_W-1:0];
        if (period_diff[TICK_W] || period_diff < {1'b0, MIN_PERIOD}) begin
            tick_d = MIN_PERIOD;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_HOLD;
            cnt_q        <= '0;
            sub_rst_q    <= 1'b1;
            run_q        <= 1'b0;
            paused_q     <= 1'b0;
            over_q       <= 1'b0;
            level_q      <= '0;
            next_thr_q   <= SCORE_W'(LEVEL_STEP);
            high_score_q <= '0;
            tick_q       <= BASE_PERIOD;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sub_rst_q <= (state_d == RESET_HOLD);
            run_q     <= (state_d == RUN);
            paused_q  <= (state_d == PAUSED);
            over_q    <= (state_d == OVER);

            if (state_q == RUN && collision && score > high_score_q) begin
                high_score_q <= score;
            end

            if (state_q == RESET_HOLD) begin
                level_q    <= '0;
                next_thr_q <= SCORE_W'(LEVEL_STEP);
                tick_q     <= BASE_PERIOD;
            end else begin
                if (state_q == RUN && score >= next_thr_q && level_q < LEVEL_W'(MAX_LEVEL)) begin
                    level_q    <= level_q + LEVEL_W'(1);
                    next_thr_q <= next_thr_q + SCORE_W'(LEVEL_STEP);
                end
                tick_q <= tick_d;
            end
        end
    end

    assign sub_rst     = sub_rst_q;
    assign run         = run_q;
    assign paused      = paused_q;
    assign game_over   = over_q;
    assign level       = level_q;
    assign tick_period = tick_q;
    assign high_score  = high_score_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with shortened timing parameters.
module tb_game_sequencer;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        collision;
    logic [31:0] score;
    logic        sub_rst;
    logic        run;
    logic        paused;
    logic        game_over;
    logic [2:0]  level;
    logic [23:0] tick_period;
    logic [31:0] high_score;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    game_sequencer #(
        .RST_CYCLES  (3),
        .DEBOUNCE    (4),
        .OVER_HOLD   (8),
        .LEVEL_STEP  (10),
        .MAX_LEVEL   (3),
        .BASE_PERIOD (24'd100),
        .PERIOD_STEP (24'd20),
        .MIN_PERIOD  (24'd50)
    ) dut (
        .system_clk  (clk),
        .rst_n       (rst_n),
        .start       (start),
        .collision   (collision),
        .score       (score),
        .sub_rst     (sub_rst),
        .run         (run),
        .paused      (paused),
        .game_over   (game_over),
        .level       (level),
        .tick_period (tick_period),
        .high_score  (high_score),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise start; on return the debounced press pulse is high and the next posedge consumes it.
    task automatic arm_press;
        @(negedge clk);
        start = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_btn;
        start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        int hi;
        repeat (3) @(negedge clk);
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_o); end
        checks++; if (sub_rst !== 1'b1) begin errors++; $display("FAIL rst_sub_rst got %b exp 1", sub_rst); end
        checks++; if (tick_period !== 24'd100) begin errors++; $display("FAIL rst_tick got %0d exp 100", tick_period); end
        checks++; if (run !== 1'b0 || high_score !== 32'd0) begin errors++; $display("FAIL rst_run_hs got run=%b hs=%0d exp 0/0", run, high_score); end
        rst_n = 1'b1;
        hi = (sub_rst === 1'b1) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sub_rst === 1'b1) hi++;
        end
        checks++; if (hi != 3) begin errors++; $display("FAIL sub_rst_len got %0d exp 3", hi); end
        checks++; if (state_o !== 3'd1 || run !== 1'b0) begin errors++; $display("FAIL wait_state got %0d run=%b exp 1 run=0", state_o, run); end
        $display("reset: sub_rst cycles=%0d state=%0d", hi, state_o);
    endtask

    task automatic test_glitch;
        @(negedge clk); start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL glitch_state got %0d exp 1", state_o); end
        collision = 1'b1;
        @(negedge clk); collision = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (state_o !== 3'd1 || game_over !== 1'b0) begin errors++; $display("FAIL wait_collision got state=%0d go=%b exp 1/0", state_o, game_over); end
        $display("glitch/collision in WAIT_START: state=%0d", state_o);
    endtask

    task automatic test_start;
        logic [2:0] prev;
        int trans;
        trans = 0;
        @(negedge clk); start = 1'b1;
        prev = state_o;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 9) start = 1'b0;
            if (state_o !== prev) trans++;
            prev = state_o;
        end
        checks++; if (trans != 1) begin errors++; $display("FAIL hold_transitions got %0d exp 1", trans); end
        checks++; if (state_o !== 3'd2 || run !== 1'b1) begin errors++; $display("FAIL start_run got state=%0d run=%b exp 2/1", state_o, run); end
        $display("start held 10 cycles: transitions=%0d state=%0d", trans, state_o);
    endtask

    task automatic test_levels;
        @(negedge clk); score = 32'd9;
        repeat (3) @(negedge clk);
        checks++; if (level !== 3'd0 || tick_period !== 24'd100) begin errors++; $display("FAIL lvl_s9 got %0d/%0d exp 0/100", level, tick_period); end
        score = 32'd10;
        @(posedge clk); #1;
        checks++; if (level !== 3'd1 || tick_period !== 24'd100) begin errors++; $display("FAIL lvl_s10a got %0d/%0d exp 1/100", level, tick_period); end
        @(posedge clk); #1;
        checks++; if (tick_period !== 24'd80) begin errors++; $display("FAIL tick_s10 got %0d exp 80", tick_period); end
        @(negedge clk); score = 32'd35;
        @(posedge clk); #1;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL lvl_s35a got %0d exp 2", level); end
        @(posedge clk); #1;
        checks++; if (level !== 3'd3 || tick_period !== 24'd60) begin errors++; $display("FAIL lvl_s35b got %0d/%0d exp 3/60", level, tick_period); end
        @(posedge clk); #1;
        checks++; if (tick_period !== 24'd50) begin errors++; $display("FAIL tick_clamp got %0d exp 50", tick_period); end
        @(negedge clk); score = 32'd100;
        repeat (4) @(negedge clk);
        checks++; if (level !== 3'd3 || tick_period !== 24'd50) begin errors++; $display("FAIL lvl_s100 got %0d/%0d exp 3/50", level, tick_period); end
        $display("levels: score=100 level=%0d tick=%0d", level, tick_period);
    endtask

    task automatic test_over_restart;
        @(negedge clk); score = 32'd42;
        arm_press;
        collision = 1'b1;
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd4 || game_over !== 1'b1 || run !== 1'b0) begin errors++; $display("FAIL over_enter got state=%0d go=%b run=%b exp 4/1/0", state_o, game_over, run); end
        checks++; if (high_score !== 32'd42) begin errors++; $display("FAIL hs_42 got %0d exp 42", high_score); end
        collision = 1'b0;
        release_btn;
        checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL over_hold got %0d exp 4", state_o); end
        arm_press;
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd0 || sub_rst !== 1'b1) begin errors++; $display("FAIL restart got state=%0d sub_rst=%b exp 0/1", state_o, sub_rst); end
        repeat (2) @(posedge clk); #1;
        checks++; if (level !== 3'd0 || tick_period !== 24'd100 || high_score !== 32'd42) begin errors++; $display("FAIL restart_vals got lvl=%0d tick=%0d hs=%0d exp 0/100/42", level, tick_period, high_score); end
        release_btn;
        $display("game over at 42, restart: hs=%0d state=%0d", high_score, state_o);
    endtask

    task automatic test_pause_resume;
        score = 32'd0;
        arm_press;
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL game2_run got %0d exp 2", state_o); end
        release_btn;
        arm_press;
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd3 || paused !== 1'b1 || run !== 1'b0) begin errors++; $display("FAIL pause got state=%0d p=%b run=%b exp 3/1/0", state_o, paused, run); end
        release_btn;
        score = 32'd50;
        collision = 1'b1;
        @(negedge clk); collision = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (state_o !== 3'd3 || level !== 3'd0) begin errors++; $display("FAIL pause_frozen got state=%0d lvl=%0d exp 3/0", state_o, level); end
        arm_press;
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd2 || level !== 3'd0) begin errors++; $display("FAIL resume got state=%0d lvl=%0d exp 2/0", state_o, level); end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            checks++; if (level !== 3'(i)) begin errors++; $display("FAIL catchup_%0d got %0d exp %0d", i, level, i); end
        end
        release_btn;
        $display("pause/resume: level=%0d", level);
    endtask

    task automatic test_early_press;
        @(negedge clk); score = 32'd30; start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); collision = 1'b1;
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd4 || high_score !== 32'd42) begin errors++; $display("FAIL over30 got state=%0d hs=%0d exp 4/42", state_o, high_score); end
        collision = 1'b0;
        repeat (6) @(posedge clk); #1;
        checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL early_press got %0d exp 4", state_o); end
        release_btn;
        arm_press;
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd0 || high_score !== 32'd42) begin errors++; $display("FAIL late_press got state=%0d hs=%0d exp 0/42", state_o, high_score); end
        release_btn;
        $display("early press ignored, late press restarts: hs=%0d", high_score);
    endtask

    task automatic test_async_reset;
        arm_press;
        @(posedge clk); #1;
        release_btn;
        arm_press;
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd3 || level !== 3'd3 || high_score !== 32'd42) begin errors++; $display("FAIL prereset got state=%0d lvl=%0d hs=%0d exp 3/3/42", state_o, level, high_score); end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (state_o !== 3'd0 || sub_rst !== 1'b1 || paused !== 1'b0 || run !== 1'b0) begin errors++; $display("FAIL async_state got st=%0d sr=%b p=%b r=%b exp 0/1/0/0", state_o, sub_rst, paused, run); end
        checks++; if (level !== 3'd0 || tick_period !== 24'd100 || high_score !== 32'd0) begin errors++; $display("FAIL async_vals got lvl=%0d tick=%0d hs=%0d exp 0/100/0", level, tick_period, high_score); end
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("async reset in PAUSED: state=%0d hs=%0d", state_o, high_score);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        collision = 1'b0;
        score     = 32'd0;
        test_reset;
        test_glitch;
        test_start;
        test_levels;
        test_over_restart;
        test_pause_resume;
        test_early_press;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
